led_progress_monitor: RTL and testbench
=======================================

Name: led_progress_monitor

Overview:
- Sits directly downstream of the multicore system. Consumes its 8-bit LED PIO word, which the Nios cores write as a progress code.
- Drives the physical LEDs and tracks filter-run state: idle, running, stalled, done.
- Measures total run time in clk_clk cycles and flags a watchdog stall when the cores stop updating progress.

Parameters:
- CNT_W, 32, width of the elapsed-time counter
- TIMEOUT_CYCLES, 100000000, cycles without a led_export change in RUN before STALL is declared
- BLINK_DIV, 12500000, cycles per blink half-period in STALL

Ports:
- clk_clk  in  1  system clock, same domain as the multicore system
- reset_reset  in  1  synchronous, active-high reset
- led_export  in  8  progress word: [7]=done, [6:4]=stage (0=idle), [3:0]=progress/16
- clear  in  1  synchronous return to IDLE
- led_out  out  8  physical LED drive
- stage  out  3  registered current stage field
- busy  out  1  high in RUN or STALL
- stall  out  1  high in STALL
- done  out  1  high in DONE
- elapsed  out  CNT_W  latched run length in cycles
- elapsed_valid  out  1  one-cycle pulse when elapsed is updated
- stage_sel  in  3  stage index for the optional per-stage readout
- stage_time  out  CNT_W  per-stage cycle count (optional feature)

Behaviour:
- Interface: one clock, clk_clk. Reset is reset_reset, synchronous and active-high. Reset has priority over clear.
- Reset values: all outputs 0; state IDLE; all counters 0.
- Input register: led_export is registered once into led_q. led_prev holds the previous led_q. chg = (led_q != led_prev).
- Latency: led_export to led_out is 2 cycles (input register plus output register). Status outputs are registered and follow the state one cycle later.
- State IDLE:
  - led_out = led_q.
  - If led_q[6:4] != 0 and led_q[7] == 0: go to RUN, run_cnt = 0, idle_cnt = 0.
  - If led_q[7] == 1: stay in IDLE (done without a start is ignored).
- State RUN:
  - run_cnt increments each cycle, saturating at all-ones.
  - idle_cnt clears on chg, otherwise increments.
  - If led_q[7] == 1: go to DONE, elapsed = run_cnt, elapsed_valid pulses for 1 cycle.
  - Else if idle_cnt == TIMEOUT_CYCLES-1: go to STALL.
  - If done and timeout occur in the same cycle, done wins.
  - led_out = led_q.
- State STALL:
  - run_cnt keeps counting.
  - led_out = led_q XOR 8'hFF on alternate blink half-periods. The blink phase starts un-inverted on entry.
  - led_q[7] == 1: go to DONE with the same latch and pulse as RUN.
  - Else chg: go to RUN, idle_cnt = 0.
- State DONE:
  - led_out = 8'hFF.
  - elapsed holds its value.
  - If led_q == 0: go to IDLE.
  - A new start code without done set does not restart the run; the cores must first write 0.
- clear: from any state, next state IDLE. Counters zeroed, elapsed zeroed, no elapsed_valid pulse.
- Blink prescaler: counts 0..BLINK_DIV-1 and toggles phase at wrap. It runs only in STALL and is reset to 0 on STALL entry.

Optional Feature:
- Macro: LED_MON_STAGE_TIMES_EN.
- With the macro defined:
  - An array of 8 CNT_W saturating counters. In RUN/STALL, counter[led_q[6:4]] increments each cycle.
  - All counters clear on the IDLE to RUN transition, on clear, and on reset.
  - stage_time = counter[stage_sel], registered with 1-cycle latency.
- Without the macro: no counter array; stage_time tied to 0; stage_sel ignored.

Decomposition:
- Package led_mon_pkg holds:
  - the state enum (IDLE, RUN, STALL, DONE)
  - field constants DONE_BIT=7, STAGE_MSB=6, STAGE_LSB=4, PROG_MSB=3
  - the LED pattern constant for DONE
- One sub-module, led_blink_gen: prescaler plus phase toggle, with enable and sync restart inputs.

Test Plan:
All scenarios use TIMEOUT_CYCLES=16 and BLINK_DIV=4.
- Reset: hold reset_reset 3 cycles with led_export=8'h15 -> all outputs 0. Two cycles after release, led_out=8'h15 and state is RUN (stage=1).
- Normal run: write 8'h10, then 8'h23 after 10 cycles, then 8'hB0 after 20 more cycles -> elapsed_valid pulses once, elapsed=30 (+/-0 by defined counting), done=1, led_out=8'hFF. Then write 8'h00 -> IDLE.
- Stall: write 8'h10 and hold -> stall=1 exactly 16 cycles after RUN entry. led_out alternates 8'h10/8'hEF every 4 cycles. Write 8'h11 -> RUN, stall=0, run_cnt continuous.
- Simultaneous: done bit arrives on the same cycle the timeout would fire -> DONE, stall never asserts.
- Clear mid-run: assert clear in RUN -> IDLE next cycle, elapsed=0, no elapsed_valid. Clear and reset together -> reset values.
- Optional feature (macro defined): stage 1 held 5 cycles, then stage 2 held 7 cycles -> stage_sel=1 reads 5, stage_sel=2 reads 7. Without the macro, stage_time reads 0.

Source files
------------

// File: rtl/led_mon_pkg.sv
// Shared state encodings, LED word field positions and the DONE pattern
// used by the LED progress monitor.
package led_mon_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_STALL = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int unsigned DONE_BIT  = 7;
    localparam int unsigned STAGE_MSB = 6;
    localparam int unsigned STAGE_LSB = 4;
    localparam int unsigned PROG_MSB  = 3;

    localparam logic [7:0] DONE_PATTERN = 8'hFF;

    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_STALL);
    endfunction

endpackage

// File: rtl/led_progress_monitor_blink.sv
// Blink prescaler for the STALL indication: counts 0..BLINK_DIV-1 while
// enabled and toggles phase at each wrap; restart forces a fresh half-period.
module led_blink_gen #(
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int unsigned PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pre_cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            pre_cnt <= '0;
            phase   <= 1'b0;
        end else if (enable) begin
            if (pre_cnt == PW'(BLINK_DIV - 1)) begin
                pre_cnt <= '0;
                phase   <= ~phase;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_progress_monitor.sv
// Tracks the multicore LED progress word, drives the LEDs and times the run.
// Optional per-stage cycle counters are built when LED_MON_STAGE_TIMES_EN is defined.
module led_progress_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned BLINK_DIV      = 12500000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [7:0]       led_export,
    input  logic             clear,
    output logic [7:0]       led_out,
    output logic [2:0]       stage,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [CNT_W-1:0] elapsed,
    output logic             elapsed_valid,
    input  logic [2:0]       stage_sel,
    output logic [CNT_W-1:0] stage_time
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [7:0]       led_q;
    logic [7:0]       led_prev;
    logic             chg;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_inc;
    logic [IDLE_W-1:0] idle_cnt;
    logic             timeout;
    logic             latch_done;
    logic             blink_phase;
    logic             run_start;

    assign chg        = (led_q != led_prev);
    assign timeout    = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign run_inc    = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    assign latch_done = is_active(state) && led_q[DONE_BIT] && !clear;
    assign run_start  = (state == ST_IDLE) && (state_nxt == ST_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (led_q[STAGE_MSB:STAGE_LSB] != '0 && !led_q[DONE_BIT])
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (led_q[DONE_BIT])
                    state_nxt = ST_DONE;
                else if (timeout)
                    state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (led_q[DONE_BIT])
                    state_nxt = ST_DONE;
                else if (chg)
                    state_nxt = ST_RUN;
            end
            default: begin
                if (led_q == '0)
                    state_nxt = ST_IDLE;
            end
        endcase
        if (clear)
            state_nxt = ST_IDLE;
    end

    led_blink_gen #(
        .BLINK_DIV(BLINK_DIV)
    ) u_blink (
        .clk    (clk_clk),
        .reset  (reset_reset),
        .enable (state == ST_STALL),
        .restart((state_nxt == ST_STALL) && (state != ST_STALL)),
        .phase  (blink_phase)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            led_q         <= '0;
            led_prev      <= '0;
            state         <= ST_IDLE;
            run_cnt       <= '0;
            idle_cnt      <= '0;
            elapsed       <= '0;
            elapsed_valid <= 1'b0;
            led_out       <= '0;
            stage         <= '0;
            busy          <= 1'b0;
            stall         <= 1'b0;
            done          <= 1'b0;
        end else begin
            led_q         <= led_export;
            led_prev      <= led_q;
            state         <= state_nxt;
            elapsed_valid <= 1'b0;

            if (clear) begin
                run_cnt  <= '0;
                idle_cnt <= '0;
                elapsed  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_start) begin
                            run_cnt  <= '0;
                            idle_cnt <= '0;
                        end
                    end
                    ST_RUN: begin
                        run_cnt  <= run_inc;
                        idle_cnt <= chg ? '0 : idle_cnt + 1'b1;
                    end
                    ST_STALL: begin
                        run_cnt <= run_inc;
                        if (state_nxt == ST_RUN)
                            idle_cnt <= '0;
                    end
                    default: ;
                endcase
                // elapsed counts every cycle spent in RUN/STALL, the exit cycle included
                if (latch_done) begin
                    elapsed       <= run_inc;
                    elapsed_valid <= 1'b1;
                end
            end

            case (state)
                ST_STALL: led_out <= blink_phase ? ~led_q : led_q;
                ST_DONE:  led_out <= DONE_PATTERN;
                default:  led_out <= led_q;
            endcase
            stage <= led_q[STAGE_MSB:STAGE_LSB];
            busy  <= is_active(state);
            stall <= (state == ST_STALL);
            done  <= (state == ST_DONE);
        end
    end

`ifdef LED_MON_STAGE_TIMES_EN
    logic [CNT_W-1:0] stage_cnt [8];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stage_cnt  <= '{default: '0};
            stage_time <= '0;
        end else begin
            if (clear || run_start) begin
                stage_cnt <= '{default: '0};
            end else if (is_active(state)) begin
                if (stage_cnt[led_q[STAGE_MSB:STAGE_LSB]] != '1)
                    stage_cnt[led_q[STAGE_MSB:STAGE_LSB]] <=
                        stage_cnt[led_q[STAGE_MSB:STAGE_LSB]] + 1'b1;
            end
            stage_time <= stage_cnt[stage_sel];
        end
    end
`else
    logic unused_stage_sel;
    assign unused_stage_sel = ^stage_sel;
    assign stage_time       = '0;
`endif

endmodule

// File: tb/tb_led_progress_monitor.sv
// Directed bench: elapsed results go through a scoreboard queue popped on
// each elapsed_valid pulse; LED and status outputs are checked inline.
module tb_led_progress_monitor;

    logic        clk_clk;
    logic        reset_reset;
    logic [7:0]  led_export;
    logic        clear;
    logic [7:0]  led_out;
    logic [2:0]  stage;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] elapsed;
    logic        elapsed_valid;
    logic [2:0]  stage_sel;
    logic [31:0] stage_time;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_st1;
    logic [31:0] exp_st2;

    led_progress_monitor #(
        .CNT_W(32),
        .TIMEOUT_CYCLES(16),
        .BLINK_DIV(4)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .led_export   (led_export),
        .clear        (clear),
        .led_out      (led_out),
        .stage        (stage),
        .busy         (busy),
        .stall        (stall),
        .done         (done),
        .elapsed      (elapsed),
        .elapsed_valid(elapsed_valid),
        .stage_sel    (stage_sel),
        .stage_time   (stage_time)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every elapsed_valid cycle must match the next expected run length.
    always @(negedge clk_clk) begin
        if (elapsed_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL elapsed_unexpected: got pulse with elapsed %0d expected no pulse", elapsed);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (elapsed !== e) begin
                    fails++;
                    $display("FAIL elapsed_value: got %0d expected %0d", elapsed, e);
                end
            end
        end
    end

    initial begin
`ifdef LED_MON_STAGE_TIMES_EN
        exp_st1 = 32'd5;
        exp_st2 = 32'd7;
`else
        exp_st1 = 32'd0;
        exp_st2 = 32'd0;
`endif
        reset_reset = 1'b1;
        clear       = 1'b0;
        led_export  = 8'h15;
        stage_sel   = 3'd0;

        // Reset values
        step(3);
        check("rst_led_out", led_out, 0);
        check("rst_stage", stage, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_elapsed", elapsed, 0);
        check("rst_elapsed_valid", elapsed_valid, 0);
        check("rst_stage_time", stage_time, 0);

        reset_reset = 1'b0;
        step(2);
        check("post_rst_led_out", led_out, 8'h15);
        check("post_rst_stage", stage, 1);
        step(1);
        check("post_rst_busy", busy, 1);
        clear = 1'b1;
        led_export = 8'h00;
        step(1);
        clear = 1'b0;
        step(1);
        check("clear_idle_busy", busy, 0);

        // Normal run: 30 cycles of RUN/STALL before done
        exp_q.push_back(32'd30);
        led_export = 8'h10;
        step(10);
        led_export = 8'h23;
        step(20);
        led_export = 8'hB0;
        step(3);
        check("run_done", done, 1);
        check("run_led_ff", led_out, 8'hFF);
        check("run_elapsed_hold", elapsed, 30);
        led_export = 8'h10;
        step(3);
        check("done_no_restart", done, 1);
        check("done_no_restart_led", led_out, 8'hFF);
        led_export = 8'h00;
        step(3);
        check("back_idle_done", done, 0);
        check("back_idle_led", led_out, 0);

        // Stall: timeout after 16 idle cycles, blink every 4 cycles, recovery
        led_export = 8'h10;
        step(3);
        check("stall_busy", busy, 1);
        check("stall_early0", stall, 0);
        step(15);
        check("stall_early15", stall, 0);
        step(1);
        check("stall_set", stall, 1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("blink_%0d", i), led_out, ((i / 4) % 2 == 1) ? 8'hEF : 8'h10);
            step(1);
        end
        led_export = 8'h11;
        step(3);
        check("recover_stall", stall, 0);
        check("recover_busy", busy, 1);
        check("recover_led", led_out, 8'h11);
        exp_q.push_back(32'd34);
        led_export = 8'hB0;
        step(3);
        check("stall_run_done", done, 1);
        led_export = 8'h00;
        step(3);

        // Clear mid-run zeroes elapsed without a pulse
        led_export = 8'h10;
        step(5);
        check("clr_busy_before", busy, 1);
        clear = 1'b1;
        led_export = 8'h00;
        step(1);
        clear = 1'b0;
        step(1);
        check("clr_busy", busy, 0);
        check("clr_elapsed", elapsed, 0);
        check("clr_done", done, 0);

        // Done on the same cycle the timeout would fire
        led_export = 8'h10;
        step(16);
        exp_q.push_back(32'd16);
        led_export = 8'h90;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("simul_stall_%0d", i), stall, 0);
        end
        check("simul_done", done, 1);
        led_export = 8'h00;
        step(3);

        // Clear and reset together
        led_export = 8'h10;
        step(3);
        reset_reset = 1'b1;
        clear = 1'b1;
        led_export = 8'h00;
        step(1);
        check("rc_led_out", led_out, 0);
        check("rc_busy", busy, 0);
        check("rc_elapsed", elapsed, 0);
        check("rc_stage", stage, 0);
        reset_reset = 1'b0;
        clear = 1'b0;
        step(2);
        check("rc_idle", busy, 0);

        // Per-stage timing: stage 1 for 5 cycles, stage 2 for 7
        exp_q.push_back(32'd13);
        led_export = 8'h10;
        step(6);
        led_export = 8'h20;
        step(7);
        led_export = 8'hB0;
        step(3);
        stage_sel = 3'd1;
        step(1);
        check("stage_time_1", stage_time, exp_st1);
        stage_sel = 3'd2;
        step(1);
        check("stage_time_2", stage_time, exp_st2);
        led_export = 8'h00;
        step(5);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
